moving_average_mc: RTL and testbench

MOVING_AVERAGE_MC -- requirements
Module: moving_average_mc

---
 rtl/moving_average_mc.sv | 202 ++++++++++++++++++++
 tb/tb_moving_average_mc.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_mc.sv
// -----------------------------------------------------------------------------
// moving_average_mc
//   Multi-channel moving-average engine. Samples from up to CHANNELS
//   time-multiplexed streams arrive on in_valid/in_ch/in_data. Each channel
//   keeps its own running sum over a window of WIN = 2**LOG2_WIN samples.
//   Two modes are available: a sliding window, which produces a result for
//   every sample once the window is full, and a block (decimating) average,
//   which produces one result per WIN samples. The result is presented exactly
//   two clocks after the sample.
//
// Parameters
//   DATA_W    sample width, two's complement
//   LOG2_WIN  log2 of the window length (1..12)
//   CHANNELS  number of channels (1..8)
//   ROUND_EN  0: average = floor(sum / WIN); 1: round half toward +inf
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clear      synchronous restart of every channel; also latches mode
//   mode       0 = sliding window, 1 = block average (sampled at reset
//              release and on clear only)
//   in_valid   sample strobe, no backpressure
//   in_ch      channel of in_data (indices >= CHANNELS are ignored)
//   in_data    signed sample
//   out_valid  one-cycle result strobe
//   out_ch     channel of the result
//   out_sum    signed window sum, full precision
//   out_avg    signed window average
// -----------------------------------------------------------------------------
module moving_average_mc #(
  parameter  int DATA_W   = 16,
  parameter  int LOG2_WIN = 10,
  parameter  int CHANNELS = 2,
  parameter  int ROUND_EN = 0,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SUM_W    = DATA_W + LOG2_WIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic signed [DATA_W-1:0] out_avg
);

  localparam int WIN    = 1 << LOG2_WIN;
  localparam int DEPTH  = CHANNELS * WIN;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int FILL_W = LOG2_WIN + 1;

  localparam logic [FILL_W-1:0]      FILL_MAX  = FILL_W'(WIN);
  localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(WIN - 1);
  localparam logic [CH_W:0]          CH_LIM    = (CH_W + 1)'(CHANNELS);
  localparam logic signed [SUM_W-1:0] HALF     = SUM_W'(WIN / 2);

  // Mode handling: mode_pend is set by reset so that the first clock after
  // release both latches mode and already uses it for that clock's sample.
  logic mode_q;
  logic mode_pend;
  logic eff_mode;

  // Per-channel state.
  logic [LOG2_WIN-1:0]     ptr  [CHANNELS];
  logic [FILL_W-1:0]       fill [CHANNELS];
  logic signed [SUM_W-1:0] acc  [CHANNELS];

  // Sample storage, one WIN-deep region per channel.
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] ram_q;

  // Stage-0 decode.
  logic                ch_ok;
  logic                accept;
  logic [FILL_W-1:0]   fill_cur;
  logic [LOG2_WIN-1:0] ptr_cur;
  logic [MEM_AW-1:0]   ram_addr;

  // Stage-1 pipeline register.
  logic                     s1_valid;
  logic [CH_W-1:0]          s1_ch;
  logic signed [DATA_W-1:0] s1_data;
  logic                     s1_old_en;  // subtract the sample leaving the window
  logic                     s1_emit;    // this sample completes a result
  logic                     s1_last;    // block mode: restart the sum afterwards

  // Stage-1 arithmetic.
  logic signed [DATA_W-1:0] old_data;
  logic signed [SUM_W-1:0]  acc_next;
  logic signed [SUM_W-1:0]  rnd_sum;

  // ---------------------------------------------------------------------------
  // Stage 0: decode the incoming sample
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a value on every path, so no latch is
  // inferred; the defaults come first and later lines refine them.
  always_comb begin
    eff_mode = mode_pend ? mode : mode_q;
    ch_ok    = ({1'b0, in_ch} < CH_LIM);
    accept   = in_valid && !clear && ch_ok;
    fill_cur = fill[in_ch];
    ptr_cur  = ptr[in_ch];
    // For a single channel the channel bit falls off the top of the address.
    ram_addr = MEM_AW'({in_ch, ptr_cur});
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples its inputs from the same, pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      mode_pend <= 1'b1;
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_data   <= '0;
      s1_old_en <= 1'b0;
      s1_emit   <= 1'b0;
      s1_last   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr[c]  <= '0;
        fill[c] <= '0;
      end
    end else begin
      mode_pend <= 1'b0;
      if (mode_pend || clear) mode_q <= mode;
      s1_valid <= accept;
      if (clear) begin
        for (int c = 0; c < CHANNELS; c++) begin
          ptr[c]  <= '0;
          fill[c] <= '0;
        end
      end else if (accept) begin
        s1_ch   <= in_ch;
        s1_data <= in_data;
        if (eff_mode) begin
          // Block mode: fill counts 0..WIN-1 and restarts with each result.
          s1_old_en   <= 1'b0;
          s1_emit     <= (fill_cur == FILL_LAST);
          s1_last     <= (fill_cur == FILL_LAST);
          fill[in_ch] <= (fill_cur == FILL_LAST) ? '0 : fill_cur + 1'b1;
        end else begin
          // Sliding mode: once full, every sample displaces the oldest one.
          s1_old_en   <= (fill_cur == FILL_MAX);
          s1_emit     <= (fill_cur >= FILL_LAST);
          s1_last     <= 1'b0;
          fill[in_ch] <= (fill_cur == FILL_MAX) ? FILL_MAX : fill_cur + 1'b1;
          ptr[in_ch]  <= ptr_cur + 1'b1;
        end
      end
    end
  end

  // NOTE: the sample memory has no reset; a channel only reads a slot after
  // it has written it since the last clear, so stale contents never matter.
  // Reading and writing the same address on one edge returns the old word,
  // which is exactly the sample leaving the window.
  always_ff @(posedge clk) begin
    if (accept && !eff_mode) mem[ram_addr] <= in_data;
    ram_q <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: update the accumulator and produce the result
  // ---------------------------------------------------------------------------
  // The accumulator is read and written only in this stage, so a sample on
  // the same channel in the very next cycle already sees the updated value.
  always_comb begin
    old_data = s1_old_en ? ram_q : '0;
    acc_next = acc[s1_ch] + SUM_W'(s1_data) - SUM_W'(old_data);
    rnd_sum  = (ROUND_EN != 0) ? acc_next + HALF : acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
      out_avg   <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      // A clear discards whatever sample is sitting in stage 1.
      out_valid <= s1_valid && s1_emit && !clear;
      if (clear) begin
        for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
      end else if (s1_valid) begin
        acc[s1_ch] <= s1_last ? '0 : acc_next;
      end
      if (s1_valid && s1_emit && !clear) begin
        out_ch  <= s1_ch;
        out_sum <= acc_next;
        // The shifted sum always fits DATA_W, so the truncation is lossless.
        out_avg <= DATA_W'(rnd_sum >>> LOG2_WIN);
      end
    end
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// -----------------------------------------------------------------------------
// tb_moving_average_mc
//   Drives four differently-configured moving_average_mc instances from one
//   shared stimulus stream and compares every output cycle with a behavioural
//   model that keeps the last WIN samples of each channel in a queue and sums
//   them directly. Directed sequences pin the model with hand-computed values;
//   a randomized stream with gaps, clears and a reset covers the rest.
//
//   u0: LOG2_WIN=2,  CHANNELS=2, floor
//   u1: LOG2_WIN=2,  CHANNELS=2, round
//   u2: LOG2_WIN=3,  CHANNELS=3, floor (channel 3 is out of range)
//   u3: LOG2_WIN=10, CHANNELS=1, round (channel 1 is out of range)
// -----------------------------------------------------------------------------
module tb_moving_average_mc;

  localparam int NI = 4;
  localparam int L2_T  [NI] = '{2, 2, 3, 10};
  localparam int NCH_T [NI] = '{2, 2, 3, 1};
  localparam int RND_T [NI] = '{0, 1, 0, 1};

  typedef struct {
    int     due;
    int     ch;
    longint sum;
    longint avg;
  } exp_t;

  typedef struct {
    int     ch;
    longint sum;
    longint avg;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, clear, mode, in_valid;
  logic [1:0]  in_ch;
  logic [15:0] in_data;

  logic        ov_a, ov_b, ov_c, ov_d;
  logic        och_a, och_b, och_d;
  logic [1:0]  och_c;
  logic [17:0] sum_a, sum_b;
  logic [18:0] sum_c;
  logic [25:0] sum_d;
  logic [15:0] avg_a, avg_b, avg_c, avg_d;

  logic   act_v   [NI];
  int     act_ch  [NI];
  longint act_sum [NI];
  longint act_avg [NI];

  exp_t   expq [NI][$];
  res_t   cap  [NI][$];
  longint hist [NI][8][$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  bit mode_m = 1'b0;
  bit pend   = 1'b1;

  always #5 clk = ~clk;

  moving_average_mc #(.DATA_W(16), .LOG2_WIN(2), .CHANNELS(2), .ROUND_EN(0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .in_valid(in_valid),
    .in_ch(in_ch[0]), .in_data(in_data), .out_valid(ov_a), .out_ch(och_a),
    .out_sum(sum_a), .out_avg(avg_a));

  moving_average_mc #(.DATA_W(16), .LOG2_WIN(2), .CHANNELS(2), .ROUND_EN(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .in_valid(in_valid),
    .in_ch(in_ch[0]), .in_data(in_data), .out_valid(ov_b), .out_ch(och_b),
    .out_sum(sum_b), .out_avg(avg_b));

  moving_average_mc #(.DATA_W(16), .LOG2_WIN(3), .CHANNELS(3), .ROUND_EN(0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .in_valid(in_valid),
    .in_ch(in_ch), .in_data(in_data), .out_valid(ov_c), .out_ch(och_c),
    .out_sum(sum_c), .out_avg(avg_c));

  moving_average_mc #(.DATA_W(16), .LOG2_WIN(10), .CHANNELS(1), .ROUND_EN(1)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .in_valid(in_valid),
    .in_ch(in_ch[0]), .in_data(in_data), .out_valid(ov_d), .out_ch(och_d),
    .out_sum(sum_d), .out_avg(avg_d));

  always_comb begin
    act_v[0] = ov_a; act_ch[0] = int'(och_a);
    act_sum[0] = longint'($signed(sum_a)); act_avg[0] = longint'($signed(avg_a));
    act_v[1] = ov_b; act_ch[1] = int'(och_b);
    act_sum[1] = longint'($signed(sum_b)); act_avg[1] = longint'($signed(avg_b));
    act_v[2] = ov_c; act_ch[2] = int'(och_c);
    act_sum[2] = longint'($signed(sum_c)); act_avg[2] = longint'($signed(avg_c));
    act_v[3] = ov_d; act_ch[3] = int'(och_d);
    act_sum[3] = longint'($signed(sum_d)); act_avg[3] = longint'($signed(avg_d));
  end

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: average of the last WIN samples of each channel.
  // ---------------------------------------------------------------------------
  function automatic longint avg_model(input int i, input longint s);
    int l = L2_T[i];
    if (RND_T[i] != 0) return (s + (longint'(1) << (l - 1))) >>> l;
    return s >>> l;
  endfunction

  task automatic flush_all();
    for (int i = 0; i < NI; i++) begin
      expq[i].delete();
      for (int c = 0; c < 8; c++) hist[i][c].delete();
    end
  endtask

  task automatic model_sample(input int i);
    int     ch;
    int     win;
    longint s;
    exp_t   e;
    ch  = (i == 2) ? int'(in_ch) : int'(in_ch[0]);
    win = 1 << L2_T[i];
    if (ch >= NCH_T[i]) return;
    hist[i][ch].push_back(longint'($signed(in_data)));
    if (!mode_m && hist[i][ch].size() > win) void'(hist[i][ch].pop_front());
    if (hist[i][ch].size() == win) begin
      s = 0;
      for (int k = 0; k < win; k++) s += hist[i][ch][k];
      e.due = cyc + 1;
      e.ch  = ch;
      e.sum = s;
      e.avg = avg_model(i, s);
      expq[i].push_back(e);
      if (mode_m) hist[i][ch].delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b1;
        flush_all();
      end else begin
        if (pend) begin
          mode_m = mode;
          pend   = 1'b0;
        end
        if (clear) begin
          mode_m = mode;
          flush_all();
        end else if (in_valid) begin
          for (int i = 0; i < NI; i++) model_sample(i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process, half a clock after each active edge.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          check($sformatf("u%0d rst out_valid @%0d", i, cyc), longint'(act_v[i]), 0);
          check($sformatf("u%0d rst out_ch @%0d", i, cyc), act_ch[i], 0);
          check($sformatf("u%0d rst out_sum @%0d", i, cyc), act_sum[i], 0);
          check($sformatf("u%0d rst out_avg @%0d", i, cyc), act_avg[i], 0);
          expq[i].delete();
        end else begin
          bit   exp_v;
          exp_t e;
          exp_v = (expq[i].size() > 0) && (expq[i][0].due == cyc);
          check($sformatf("u%0d out_valid @%0d", i, cyc), longint'(act_v[i]), longint'(exp_v));
          if (exp_v) begin
            e = expq[i].pop_front();
            if (act_v[i]) begin
              check($sformatf("u%0d out_ch @%0d", i, cyc), act_ch[i], e.ch);
              check($sformatf("u%0d out_sum @%0d", i, cyc), act_sum[i], e.sum);
              check($sformatf("u%0d out_avg @%0d", i, cyc), act_avg[i], e.avg);
            end
          end
          if (act_v[i]) begin
            res_t r;
            r.ch  = act_ch[i];
            r.sum = act_sum[i];
            r.avg = act_avg[i];
            cap[i].push_back(r);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input int ch, input int d);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_data  = 16'(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear(input bit m);
    clear = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < NI; i++) cap[i].delete();
  endtask

  task automatic chk_res(input string nm, input int i, input int idx,
                         input int ch, input longint s, input longint a);
    if (idx < cap[i].size()) begin
      check({nm, " ch"}, cap[i][idx].ch, ch);
      check({nm, " sum"}, cap[i][idx].sum, s);
      check({nm, " avg"}, cap[i][idx].avg, a);
    end else begin
      check({nm, " present"}, cap[i].size(), idx + 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int d;
    rst = 1'b1; clear = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Sliding window of 4, back to back: results 40/10 then 56/14.
    clear_caps();
    send(0, 4); send(0, 8); send(0, 12); send(0, 16); send(0, 20);
    idle(4);
    check("ramp count", cap[0].size(), 2);
    chk_res("ramp r0", 0, 0, 0, 40, 10);
    chk_res("ramp r1", 0, 1, 0, 56, 14);
    chk_res("ramp rnd r0", 1, 0, 0, 40, 10);

    // Negative rounding: -5/4 floors to -2, rounds to -1.
    do_clear(1'b0);
    clear_caps();
    send(0, -1); send(0, -1); send(0, -1); send(0, -2);
    idle(4);
    chk_res("neg floor", 0, 0, 0, -5, -2);
    chk_res("neg round", 1, 0, 0, -5, -1);

    // Block mode, two interleaved channels.
    do_clear(1'b1);
    clear_caps();
    for (int k = 0; k < 4; k++) begin
      send(0, k + 1);
      send(1, 100);
    end
    idle(4);
    check("block count", cap[0].size(), 2);
    chk_res("block ch0", 0, 0, 0, 10, 2);
    chk_res("block ch1", 0, 1, 1, 400, 100);

    // Clear after three samples discards them.
    do_clear(1'b0);
    clear_caps();
    send(0, 9); send(0, 9); send(0, 9);
    do_clear(1'b0);
    send(0, 5); send(0, 5); send(0, 5); send(0, 5);
    idle(4);
    check("clear count", cap[0].size(), 1);
    chk_res("clear r0", 0, 0, 0, 20, 5);

    // Reset mid-stream aborts in-flight work; a new window must fill.
    clear_caps();
    send(0, 7); send(0, 7);
    in_valid = 1'b1; in_data = 16'd7; rst = 1'b1;
    idle(2);
    rst = 1'b0; in_valid = 1'b0;
    send(0, 3); send(0, 3); send(0, 3);
    idle(3);
    check("rst no early result", cap[0].size(), 0);
    send(0, 3);
    idle(4);
    chk_res("rst r0", 0, 0, 0, 12, 3);

    // Full-scale window of 1024: no wrap at either extreme.
    do_clear(1'b0);
    clear_caps();
    for (int k = 0; k < 3000; k++) send(0, 32767);
    for (int k = 0; k < 1024; k++) send(0, -32768);
    idle(4);
    check("fullscale count", cap[3].size(), 3001);
    chk_res("fullscale max", 3, 0, 0, 33553408, 32767);
    chk_res("fullscale min", 3, 3000, 0, -33554432, -32768);

    // Randomized stream.
    do_clear(1'b0);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst = 1'b1; in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        do_clear(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 7))
          0:       d = 32767;
          1:       d = -32768;
          default: d = int'($urandom_range(0, 65535));
        endcase
        send(int'($urandom_range(0, 3)), d);
      end else begin
        idle(1);
      end
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
